// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_ctrl slice: FSM states, rate table,
// half-period helper and default counter width.
package clk_div_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned RATE0_HZ      = 1000;
    localparam int unsigned RATE1_HZ      = 500;
    localparam int unsigned RATE2_HZ      = 100;
    localparam int unsigned RATE3_HZ      = 10;
    localparam int unsigned DEFAULT_CNT_W = 17;

    // Clock cycles per half period of the divided output.
    function automatic int unsigned half_cnt(input int unsigned clk_in_freq,
                                             input int unsigned rate);
        return clk_in_freq / (2 * rate);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and clk_out toggle flop; boundary flags the terminal count
// of the high phase, i.e. the falling edge that completes a full period.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] half,
    input  logic             run,
    output logic             clk_out,
    output logic             boundary
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             w_term;

    assign w_term   = (r_cnt == half - CNT_W'(1));
    assign boundary = run & w_term & r_clk;
    assign clk_out  = r_clk;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
        end else if (!run) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
        end else if (w_term) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
        end else if (load) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop FSM, glitch-free rate-change req/ack handshake and tick around clk_div_core.
// Define CLK_DIV_CTRL_TICK_EN to generate tick; otherwise tick is tied low.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned CLK_IN_FREQ = 1_000_000,
    parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] rate_sel,
    input  logic       req,
    output logic       busy,
    output logic       ack,
    output logic [1:0] cur_rate,
    output logic       clk_out,
    output logic       tick
);

    localparam logic [CNT_W-1:0] HALF0 = CNT_W'(half_cnt(CLK_IN_FREQ, RATE0_HZ));
    localparam logic [CNT_W-1:0] HALF1 = CNT_W'(half_cnt(CLK_IN_FREQ, RATE1_HZ));
    localparam logic [CNT_W-1:0] HALF2 = CNT_W'(half_cnt(CLK_IN_FREQ, RATE2_HZ));
    localparam logic [CNT_W-1:0] HALF3 = CNT_W'(half_cnt(CLK_IN_FREQ, RATE3_HZ));

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             r_ack;
    logic             r_applied;
    logic [1:0]       r_cur_rate;
    logic [1:0]       r_pend_rate;
    logic [CNT_W-1:0] w_half;
    logic             w_run;
    logic             w_boundary;
    logic             w_clk_out;
    logic             w_accept;
    logic             w_apply;

    always_comb begin
        w_half = HALF0;
        case (r_cur_rate)
            2'd1:    w_half = HALF1;
            2'd2:    w_half = HALF2;
            2'd3:    w_half = HALF3;
            default: w_half = HALF0;
        endcase
    end

    assign w_run = (r_state != STOP);

    clk_div_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk_in  (clk_in),
        .rst     (rst),
        .load    (w_apply),
        .half    (w_half),
        .run     (w_run),
        .clk_out (w_clk_out),
        .boundary(w_boundary)
    );

    // Stopped divider applies at once; running divider waits for a full period to end.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = req & ~r_busy;
        w_apply     = r_busy & ~r_applied & ((r_state == STOP) | w_boundary);
        case (r_state)
            STOP:    if (en) w_state_nxt = RUN;
            RUN:     if (!en) w_state_nxt = DRAIN;
            DRAIN: begin
                if (en)              w_state_nxt = RUN;
                else if (w_boundary) w_state_nxt = STOP;
            end
            default: w_state_nxt = STOP;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state     <= STOP;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_applied   <= 1'b0;
            r_cur_rate  <= 2'd0;
            r_pend_rate <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_applied <= w_apply;
            r_ack     <= r_applied;
            if (r_applied)     r_busy <= 1'b0;
            else if (w_accept) r_busy <= 1'b1;
            if (w_accept) r_pend_rate <= rate_sel;
            if (w_apply)  r_cur_rate  <= r_pend_rate;
        end
    end

    assign busy     = r_busy;
    assign ack      = r_ack;
    assign cur_rate = r_cur_rate;
    assign clk_out  = w_clk_out;

`ifdef CLK_DIV_CTRL_TICK_EN
    logic r_clk_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) r_clk_q <= 1'b0;
        else     r_clk_q <= w_clk_out;
    end

    assign tick = w_clk_out & ~r_clk_q;
`else
    assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed and randomized bench for clk_div_ctrl; a period-position model of the
// divider and handshake supplies the expected outputs every cycle.
module tb_clk_div_ctrl;

    localparam int unsigned FREQ = 1_000_000;

    logic       clk_in   = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b0;
    logic       req      = 1'b0;
    logic [1:0] rate_sel = 2'd0;
    logic       busy;
    logic       ack;
    logic       clk_out;
    logic       tick;
    logic [1:0] cur_rate;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    // Reference model: position inside the current output period, 0..2*HALF-1.
    bit m_on, m_drain, m_busy, m_applied, m_ack;
    int m_pos, m_rate, m_pend;

    clk_div_ctrl #(
        .CLK_IN_FREQ(FREQ),
        .CNT_W      (17)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .rate_sel(rate_sel),
        .req     (req),
        .busy    (busy),
        .ack     (ack),
        .cur_rate(cur_rate),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    function automatic int half_of(input int r);
        case (r)
            0:       return 500;
            1:       return 1000;
            2:       return 5000;
            default: return 50000;
        endcase
    endfunction

    function automatic logic [5:0] exp_vec();
        bit c, t;
        int h;
        h = half_of(m_rate);
        c = m_on && (m_pos >= h);
`ifdef CLK_DIV_CTRL_TICK_EN
        t = m_on && (m_pos == h);
`else
        t = 1'b0;
`endif
        return {c, t, m_ack, m_busy, 2'(m_rate)};
    endfunction

    function automatic logic [5:0] act_vec();
        return {clk_out, tick, ack, busy, cur_rate};
    endfunction

    task automatic model_reset();
        m_on = 0; m_drain = 0; m_busy = 0; m_applied = 0; m_ack = 0;
        m_pos = 0; m_rate = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit e, input bit r, input int s);
        int h;
        bit bnd, apply, acc;
        h     = half_of(m_rate);
        bnd   = m_on && (m_pos == 2 * h - 1);
        apply = m_busy && !m_applied && (!m_on || bnd);
        acc   = r && !m_busy;
        m_ack = m_applied;
        if (m_applied) m_busy = 0;
        else if (acc)  m_busy = 1;
        m_applied = apply;
        if (apply) m_rate = m_pend;
        if (acc)   m_pend = s;
        if (!m_on) begin
            if (e) begin m_on = 1; m_drain = 0; m_pos = 0; end
        end else begin
            m_pos = bnd ? 0 : m_pos + 1;
            if (!m_drain)   m_drain = !e;
            else if (e)     m_drain = 0;
            else if (bnd) begin m_on = 0; m_drain = 0; m_pos = 0; end
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        if (rst) model_reset();
        else     model_step(en, req, int'(rate_sel));
        @(negedge clk_in);
        cyc_n++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 1'b1; rate_sel = 2'd3;
        model_reset();
        repeat (3) begin
            cyc();
            if (act_vec() !== 6'b0) begin
                n_fail++; $display("FAIL reset_outputs cyc %0d: got %b want %b", cyc_n, act_vec(), 6'b0);
            end
            n_checks++;
        end
        en = 1'b0; req = 1'b0; rate_sel = 2'd0; rst = 1'b0;
    endtask

    task automatic test_startup();
        int n0, r1, r2, ticks;
        logic prev;
        r1 = -1; r2 = -1; ticks = 0;
        cyc();
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL startup_idle cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
        end
        n_checks++;
        prev = clk_out;
        en = 1'b1; n0 = cyc_n + 1;
        for (int i = 0; i < 2600; i++) begin
            cyc();
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL startup_cycle cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
            end
            n_checks++;
            if (tick === 1'b1) ticks++;
            if (clk_out === 1'b1 && prev !== 1'b1) begin
                if (r1 < 0) r1 = cyc_n;
                else if (r2 < 0) r2 = cyc_n;
            end
            prev = clk_out;
        end
        if ((r1 - n0) !== 500) begin
            n_fail++; $display("FAIL startup_first_rise: got %0d cycles want 500", r1 - n0);
        end
        n_checks++;
        if ((r2 - r1) !== 1000) begin
            n_fail++; $display("FAIL startup_period: got %0d cycles want 1000", r2 - r1);
        end
        n_checks++;
`ifdef CLK_DIV_CTRL_TICK_EN
        if (ticks !== 3) begin n_fail++; $display("FAIL startup_ticks: got %0d want 3", ticks); end
`else
        if (ticks !== 0) begin n_fail++; $display("FAIL startup_ticks: got %0d want 0", ticks); end
`endif
        n_checks++;
    endtask

    task automatic test_rate_switch();
        int acks, ack_at, f1, f2, r1;
        bit found;
        logic prev;
        acks = 0; ack_at = -1; f1 = -1; f2 = -1; r1 = -1; found = 0;
        prev = clk_out;
        for (int i = 0; i < 1100 && !found; i++) begin
            cyc();
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL switch_wait cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
            end
            n_checks++;
            if (clk_out === 1'b1 && prev !== 1'b1) found = 1;
            prev = clk_out;
        end
        if (!found) begin n_fail++; $display("FAIL switch_rise_timeout: got no rise want rise"); end
        n_checks++;
        repeat (250) begin
            cyc();
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL switch_mid cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
            end
            n_checks++;
        end
        req = 1'b1; rate_sel = 2'd2;
        prev = clk_out;
        for (int i = 0; i < 11500; i++) begin
            cyc();
            req = 1'b0; rate_sel = 2'($urandom_range(0, 3));
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL switch_cycle cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
            end
            n_checks++;
            if (ack === 1'b1) begin acks++; if (ack_at < 0) ack_at = cyc_n; end
            if (clk_out === 1'b0 && prev === 1'b1) begin
                if (f1 < 0) f1 = cyc_n;
                else if (f2 < 0) f2 = cyc_n;
            end
            if (clk_out === 1'b1 && prev === 1'b0 && f1 >= 0 && r1 < 0) r1 = cyc_n;
            prev = clk_out;
        end
        if (acks !== 1) begin n_fail++; $display("FAIL switch_ack_count: got %0d want 1", acks); end
        n_checks++;
        if ((ack_at - f1) !== 1) begin
            n_fail++; $display("FAIL switch_ack_after_fall: got %0d want 1", ack_at - f1);
        end
        n_checks++;
        if ((r1 - f1) !== 5000 || (f2 - r1) !== 5000) begin
            n_fail++; $display("FAIL switch_new_phases: got low %0d high %0d want 5000 5000", r1 - f1, f2 - r1);
        end
        n_checks++;
        if (cur_rate !== 2'd2) begin n_fail++; $display("FAIL switch_cur_rate: got %0d want 2", cur_rate); end
        n_checks++;
    endtask

    task automatic test_busy_ignore();
        int acks;
        acks = 0;
        req = 1'b1; rate_sel = 2'd1;
        cyc();
        req = 1'b0;
        cyc();
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_set: got %b want 1", busy); end
        n_checks++;
        req = 1'b1; rate_sel = 2'd3;
        for (int i = 0; i < 10100; i++) begin
            cyc();
            if (i == 2) req = 1'b0;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL busy_cycle cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
            end
            n_checks++;
            if (ack === 1'b1) acks++;
        end
        if (acks !== 1) begin n_fail++; $display("FAIL busy_ack_count: got %0d want 1", acks); end
        n_checks++;
        if (cur_rate !== 2'd1) begin n_fail++; $display("FAIL busy_cur_rate: got %0d want 1", cur_rate); end
        n_checks++;
    endtask

    task automatic test_drain();
        int acks, f1, rises_after;
        bit found;
        logic prev;
        acks = 0; f1 = -1; rises_after = 0; found = 0;
        prev = clk_out;
        for (int i = 0; i < 2100 && !found; i++) begin
            cyc();
            if (clk_out === 1'b1 && prev !== 1'b1) found = 1;
            prev = clk_out;
        end
        if (!found) begin n_fail++; $display("FAIL drain_rise_timeout: got no rise want rise"); end
        n_checks++;
        repeat (300) cyc();
        req = 1'b1; rate_sel = 2'd0;
        cyc();
        req = 1'b0; en = 1'b0;
        prev = clk_out;
        for (int i = 0; i < 2400; i++) begin
            cyc();
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL drain_cycle cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
            end
            n_checks++;
            if (ack === 1'b1) acks++;
            if (clk_out === 1'b0 && prev === 1'b1 && f1 < 0) f1 = cyc_n;
            if (clk_out === 1'b1 && prev === 1'b0 && f1 >= 0) rises_after++;
            prev = clk_out;
        end
        if (f1 < 0 || rises_after !== 0 || clk_out !== 1'b0) begin
            n_fail++; $display("FAIL drain_stop: got fall %0d rises %0d clk %b want fall>=0 rises 0 clk 0", f1, rises_after, clk_out);
        end
        n_checks++;
        if (acks !== 1 || cur_rate !== 2'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drain_apply: got acks %0d rate %0d busy %b want 1 0 0", acks, cur_rate, busy);
        end
        n_checks++;
    endtask

    task automatic test_stop_req();
        int e, ack_at;
        ack_at = -1;
        en = 1'b0; req = 1'b1; rate_sel = 2'd3; e = cyc_n + 1;
        cyc();
        req = 1'b0; rate_sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stop_cycle cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
            end
            n_checks++;
            if (ack === 1'b1 && ack_at < 0) ack_at = cyc_n;
        end
        if ((ack_at - e) !== 2) begin n_fail++; $display("FAIL stop_ack_latency: got %0d want 2", ack_at - e); end
        n_checks++;
        if (cur_rate !== 2'd3 || clk_out !== 1'b0) begin
            n_fail++; $display("FAIL stop_apply: got rate %0d clk %b want 3 0", cur_rate, clk_out);
        end
        n_checks++;
        req = 1'b1; rate_sel = 2'd0;
        cyc();
        req = 1'b0;
        repeat (4) cyc();
        if (cur_rate !== 2'd0) begin n_fail++; $display("FAIL stop_restore: got %0d want 0", cur_rate); end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        int n0, r1, acks;
        logic prev;
        r1 = -1; acks = 0;
        en = 1'b1;
        repeat (700) cyc();
        req = 1'b1; rate_sel = 2'd2;
        cyc();
        req = 1'b0;
        cyc();
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b want 1", busy); end
        n_checks++;
        #2;
        rst = 1'b1;
        #1;
        if (act_vec() !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_async_clear: got %b want %b", act_vec(), 6'b0);
        end
        n_checks++;
        model_reset();
        repeat (3) begin
            cyc();
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rstmid_hold cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
            end
            n_checks++;
        end
        rst = 1'b0; en = 1'b1; n0 = cyc_n + 1;
        prev = clk_out;
        for (int i = 0; i < 1600; i++) begin
            cyc();
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rstmid_cycle cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
            end
            n_checks++;
            if (ack === 1'b1) acks++;
            if (clk_out === 1'b1 && prev !== 1'b1 && r1 < 0) r1 = cyc_n;
            prev = clk_out;
        end
        if (acks !== 0 || cur_rate !== 2'd0) begin
            n_fail++; $display("FAIL rstmid_discard: got acks %0d rate %0d want 0 0", acks, cur_rate);
        end
        n_checks++;
        if ((r1 - n0) !== 500) begin n_fail++; $display("FAIL rstmid_restart: got %0d want 500", r1 - n0); end
        n_checks++;
    endtask

    task automatic test_random();
        en = 1'b1;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 399) == 0) en = ~en;
            req      = ($urandom_range(0, 149) == 0);
            rate_sel = 2'($urandom_range(0, 1));
            cyc();
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle cyc %0d: got %b want %b", cyc_n, act_vec(), exp_vec());
            end
            n_checks++;
        end
        req = 1'b0; en = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_startup();
        test_rate_switch();
        test_busy_ignore();
        test_drain();
        test_stop_req();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable clock divider controller. It owns a shared divider counter, selects one of four fixed target rates, and starts or stops the divided clock. Rate changes go through a req/ack handshake and take effect only at a period boundary, so `clk_out` never glitches. It sits between lab control logic (switches, FSMs) and any downstream logic clocked or enabled by the divided output.

## Interface
- `CLK_IN_FREQ`, default 1_000_000: input clock frequency in Hz.
- `CNT_W`, default 17: half-period counter width. Must hold `CLK_IN_FREQ/(2*min rate)`.
- `clk_in`, in, 1: input clock, single domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: run request (level).
- `rate_sel`, in, 2: requested rate index, sampled on an accepted `req`.
- `req`, in, 1: rate-change request (level or pulse).
- `busy`, out, 1: a rate change is pending.
- `ack`, out, 1: one-cycle pulse when the new rate is applied.
- `cur_rate`, out, 2: rate index currently in effect.
- `clk_out`, out, 1: divided clock, registered.
- `tick`, out, 1: one-cycle pulse on each `clk_out` rising transition.

## Operation
- Rate table, index 0..3: 1000, 500, 100, 10 Hz.
- Half-period count is `HALF = CLK_IN_FREQ/(2*rate)`, integer division, computed at elaboration.
- Counter runs `cnt` from 0 to HALF-1. At terminal count: `clk_out` toggles and `cnt` returns to 0.
- FSM states:
  - STOP: `clk_out`=0, `cnt`=0.
  - RUN: counting.
  - DRAIN: `en` has dropped; finishing the current period.
- Transitions:
  - STOP→RUN on `en`=1.
  - RUN→DRAIN on `en`=0.
  - DRAIN→STOP at the period boundary.
  - DRAIN→RUN if `en` returns to 1 before the boundary.
- Period boundary: terminal count while `clk_out`=1, i.e. the falling edge, completing a full period.
- Handshake:
  - `req`=1 while `busy`=0 latches `rate_sel` into `pend_rate` and sets `busy`.
  - `req` while `busy`=1 is ignored. No second ack, and the latched value is unchanged.
- Apply point:
  - In RUN or DRAIN: at the next period boundary, `cur_rate`←`pend_rate` and the counter reloads under the new HALF.
  - In STOP: on the cycle after acceptance.
- `ack` pulses the cycle after apply. `busy` clears in that same cycle.
- Simultaneous events:
  - `req` accepted in the same cycle as a boundary applies at the following boundary, not the current one.
  - `en` falling with a pending request: the request applies at the DRAIN→STOP boundary.
- Reset mid-operation: everything returns to reset values immediately and any pending request is discarded without an ack.

## Timing
- Reset values:
  - `clk_out`=0, `tick`=0, `ack`=0, `busy`=0, `cur_rate`=0.
  - FSM=STOP, `cnt`=0, `pend_rate`=0.
- Start-up: `en` is sampled high at edge N. `clk_out` is low for cycles N+1..N+HALF and rises at edge N+HALF.
- Steady state: `clk_out` period is exactly 2·HALF `clk_in` cycles at 50 % duty.
- `tick` is high in the cycle `clk_out` first reads 1.
- Handshake latency:
  - Running: `ack` is at most 2·HALF_old+1 cycles after acceptance.
  - Stopped: `ack` is 2 cycles after the `req` edge.
- The first period after a switch uses the new HALF for both phases.

## Configuration
- `CLK_DIV_CTRL_TICK_EN`:
  - Defined: `tick` is generated as described.
  - Undefined: `tick` is tied to 0 and its logic is removed; the port remains.
  - Nothing else changes.

## Structure
- Package `clk_div_pkg` holds:
  - the FSM state enum (STOP, RUN, DRAIN);
  - the rate table constants;
  - a constant function `half_cnt(clk_in_freq, rate)`;
  - the default `CNT_W`.
- Sub-module `clk_div_core` holds the counter and toggle flop. Its inputs are `load`, `half`, and `run`; its outputs are `clk_out` and `boundary`.
- `clk_div_ctrl` holds the FSM, handshake, and tick logic.

## Test plan
All scenarios use `CLK_IN_FREQ`=1_000_000, so HALF is 500, 1000, 5000 and 50000.
- Reset, then `en`=1 at rate 0 → `clk_out` rises 500 cycles later, period 1000 cycles, `tick` every 1000 cycles, and all outputs 0 during reset.
- Running at rate 0, `req` with `rate_sel`=2 mid-high-phase → switch at the falling edge, next high phase 5000 cycles, one `ack`, `cur_rate`=2.
- `req` with `rate_sel`=1 while `busy`, then again with 3 → only the first applies, a single `ack`, `cur_rate`=1.
- STOP with `req` `rate_sel`=3 → `ack` 2 cycles later, `cur_rate`=3, `clk_out` stays 0.
- `en` dropped mid-high-phase with a pending request → period completes, `clk_out`=0 in STOP, request applied at the boundary, `ack` follows.
- `rst` asserted mid-period with `busy`=1 → immediate clear, no `ack`, restart at rate 0.
